encoder_ctrl: RTL
=================

Name: encoder_ctrl

Overview:
Sequencer for one Encoder instance (per-dimension bit accumulators, shared element counter, majority threshold). Clears the encoder, streams exactly `cfg_num` feature hypervectors into it over a valid/ready input, waits for the accumulators to settle, then holds the bundled hypervector on a valid/ready output. Sits between the feature-fetch stage and the downstream similarity/classification stage.

Parameters:
DIM, `DIM, hypervector width in bits (matches dw_t).
CNT_W, 8, encoder counter width; legal cfg_num range is 1..2^CNT_W-1.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
start  in  1  request a new encode; sampled only in IDLE.
cfg_num  in  CNT_W  number of features per sample; latched on accepted start.
busy  out  1  high in every state except IDLE.
err  out  1  one-cycle pulse: start seen in IDLE with cfg_num==0.
in_valid  in  1  feature hypervector valid.
in_data  in  DIM  feature hypervector.
in_ready  out  1  controller accepts a feature this cycle.
enc_clr  out  1  to Encoder clr.
enc_en  out  1  to Encoder en.
enc_data  out  DIM  to Encoder data.
enc_in  in  DIM  from Encoder enc.
out_valid  out  1  encoded result valid.
out_data  out  DIM  registered encoded result.
out_ready  in  1  downstream accepts result.
feat_cnt  out  CNT_W  features accepted in the current sample.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; busy, err, in_ready, enc_clr, enc_en, out_valid = 0; out_data, feat_cnt, latched num = 0. Reset mid-operation discards the sample in progress; the Encoder is not cleared by reset (the next CLEAR cycle does it).
- States: IDLE, CLEAR, ACCUM, SETTLE, DONE.
- IDLE: start=1 and cfg_num!=0 -> latch num=cfg_num, feat_cnt=0, go CLEAR. start=1 and cfg_num==0 -> err=1 next cycle, stay IDLE. start=0 -> stay IDLE.
- CLEAR (exactly 1 cycle): enc_clr=1, enc_en=0, in_ready=0 -> ACCUM.
- ACCUM: in_ready=1 (combinational from state). Beat = in_valid & in_ready. On a beat, enc_en=1 and enc_data=in_data in the same cycle (combinational pass-through), and feat_cnt increments. enc_en=0 on non-beat cycles. When the beat brings the count to num, go SETTLE. in_ready=0 in SETTLE, so extra features are not taken. in_valid gaps are allowed with no limit.
- SETTLE (exactly 1 cycle): the Encoder registers were updated by the last beat, so enc_in now reflects all num features. Capture out_data<=enc_in, go DONE.
- DONE: out_valid=1 and out_data stable until the handshake. out_valid & out_ready -> IDLE and out_valid=0 next cycle. start is ignored in DONE.
- enc_clr and enc_en are never high together. enc_data=0 whenever no beat occurs.
- Latency:
  - Accepted start at cycle t gives CLEAR at t+1, with the first possible beat at t+2.
  - Last beat at cycle b gives SETTLE at b+1 and out_valid=1 from b+2.
  - Minimum start-to-out_valid with back-to-back input is num+3 cycles.
- Majority rule (performed inside the Encoder, which sees element count = num): enc bit d = 1 iff the count of 1s in dim d is > (num>>1). Ties (even num, exactly num/2 ones) give 0. The controller does no arithmetic on the data.
- feat_cnt holds its final value (num) through SETTLE/DONE and resets to 0 on the next accepted start.
- Busy back-pressure: while not in IDLE, start has no effect and no err is raised.

Test Plan:
1. DIM=8, cfg_num=3, back-to-back features 0xF0, 0xCC, 0xAA -> enc_clr one cycle after start; enc_en high 3 consecutive cycles; out_valid at start+6; out_data=0xE8 (bitwise majority >1).
2. cfg_num=2, features 0xFF, 0x0F -> out_data=0x0F (a 1/2 tie gives 0). Then cfg_num=1, feature 0x5A -> out_data=0x5A, proving CLEAR reset the prior accumulation.
3. cfg_num=4 with in_valid toggling 1,0,0,1,1,0,1 -> exactly 4 enc_en pulses aligned to beats; in_ready=0 after the 4th beat; a 5th in_valid is not consumed; feat_cnt=4.
4. out_ready held 0 for 10 cycles in DONE -> out_valid and out_data stable; a start pulse meanwhile is ignored; out_ready=1 -> IDLE next cycle and busy=0.
5. start with cfg_num=0 -> err pulse of 1 cycle, busy stays 0, no enc_clr. Then cfg_num=255, 255 features of 0x01 -> out_data=0x01.
6. rst=1 during ACCUM after 2 of 5 beats -> next cycle all outputs at reset values. A new start with cfg_num=1, feature 0x33 -> out_data=0x33.

Source files
------------

// File: rtl/encoder_ctrl.sv
// Sequencer for one bit-accumulating Encoder: clear, stream cfg_num features,
// let the accumulators settle, then hold the bundled hypervector for downstream.
module encoder_ctrl #(
  parameter int DIM   = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_num,
  output logic             busy,
  output logic             err,
  input  logic             in_valid,
  input  logic [DIM-1:0]   in_data,
  output logic             in_ready,
  output logic             enc_clr,
  output logic             enc_en,
  output logic [DIM-1:0]   enc_data,
  input  logic [DIM-1:0]   enc_in,
  output logic             out_valid,
  output logic [DIM-1:0]   out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] feat_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    ACCUM  = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] num;
  logic [CNT_W-1:0] cnt_inc;
  logic             beat;
  logic             start_ok;
  logic             start_bad;

  assign in_ready  = (state == ACCUM);
  assign beat      = in_valid & in_ready;
  assign cnt_inc   = feat_cnt + 1'b1;
  assign start_ok  = (state == IDLE) && start && (cfg_num != '0);
  assign start_bad = (state == IDLE) && start && (cfg_num == '0);

  // Encoder-facing strobes are pure decodes of state/beat, so clr and en
  // can never overlap and data is zero on every non-beat cycle.
  assign busy      = (state != IDLE);
  assign enc_clr   = (state == CLEAR);
  assign enc_en    = beat;
  assign enc_data  = beat ? in_data : '0;
  assign out_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = CLEAR;
      CLEAR:   state_nxt = ACCUM;
      ACCUM:   if (beat && (cnt_inc == num)) state_nxt = SETTLE;
      SETTLE:  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      num      <= '0;
      feat_cnt <= '0;
      out_data <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= start_bad;
      if (start_ok) begin
        num      <= cfg_num;
        feat_cnt <= '0;
      end else if (beat) begin
        feat_cnt <= cnt_inc;
      end
      // Last beat landed in the Encoder on the previous edge; enc_in is final now.
      if (state == SETTLE) out_data <= enc_in;
    end
  end

endmodule
